// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory with a
// fixed multi-cycle access latency and out-of-range address protection.
module data_mem_arbiter #(
    parameter int WORD_SIZE     = 32,
    parameter int DATA_MEM_SIZE = 1024,
    parameter int MEM_LATENCY   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 we0,
    input  logic [WORD_SIZE-1:0] addr0,
    input  logic [WORD_SIZE-1:0] wdata0,
    input  logic                 lb0,
    input  logic                 req1,
    input  logic                 we1,
    input  logic [WORD_SIZE-1:0] addr1,
    input  logic [WORD_SIZE-1:0] wdata1,
    input  logic                 lb1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 rdy0,
    output logic                 rdy1,
    output logic                 err0,
    output logic                 err1,
    output logic [WORD_SIZE-1:0] rdata0,
    output logic [WORD_SIZE-1:0] rdata1,
    output logic                 memWE,
    output logic                 memLB,
    output logic [WORD_SIZE-1:0] memA,
    output logic [WORD_SIZE-1:0] memWD,
    input  logic [WORD_SIZE-1:0] memRD,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

    localparam logic [WORD_SIZE-1:0] MEM_WORDS = WORD_SIZE'(DATA_MEM_SIZE);
    localparam logic [3:0]           CNT_LOAD  = 4'(MEM_LATENCY - 1);

    state_t               state;
    logic [3:0]           cnt;
    logic                 last;
    logic                 owner;
    logic                 we_q;
    logic                 lb_q;
    logic                 err_q;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;

    logic                 pick1;
    logic                 in_idle;
    logic                 in_access;

    // Port 1 wins when it is the only requester, or on a tie when port 0 went last.
    assign pick1     = req1 && (!req0 || !last);
    assign in_idle   = rst && (state == IDLE);
    assign in_access = (state == ACCESS);

    assign gnt0  = in_idle && req0 && !pick1;
    assign gnt1  = in_idle && pick1;
    assign busy  = (state != IDLE);

    assign memWE = in_access && (cnt == 4'd0) && we_q && !err_q;
    assign memLB = in_access && lb_q;
    assign memA  = in_access ? addr_q  : '0;
    assign memWD = in_access ? wdata_q : '0;

    assign rdy0  = (state == DONE) && !owner;
    assign rdy1  = (state == DONE) && owner;
    assign err0  = rdy0 && err_q;
    assign err1  = rdy1 && err_q;

    // NOTE: every register here is assigned with <= so all of them update from
    // the same pre-edge values; a blocking = would let later lines see new ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            last    <= 1'b1;
            owner   <= 1'b0;
            we_q    <= 1'b0;
            lb_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner   <= pick1;
                        last    <= pick1;
                        we_q    <= pick1 ? we1    : we0;
                        lb_q    <= pick1 ? lb1    : lb0;
                        addr_q  <= pick1 ? addr1  : addr0;
                        wdata_q <= pick1 ? wdata1 : wdata0;
                        err_q   <= (pick1 ? addr1 : addr0) >= MEM_WORDS;
                        cnt     <= CNT_LOAD;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        // Out-of-range reads return zero instead of whatever the memory drives.
                        if (!we_q) begin
                            if (owner) rdata1 <= err_q ? '0 : memRD;
                            else       rdata0 <= err_q ? '0 : memRD;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a transaction-timing model.
module tb_data_mem_arbiter;

    localparam int L     = 3;
    localparam int WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, lb0, req1, we1, lb1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, gnt1, rdy0, rdy1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        memWE, memLB, busy;
    logic [31:0] memA, memWD, memRD;

    // Second instance with single-cycle memory latency.
    logic        l1_req;
    logic [31:0] l1_addr;
    logic        l1_gnt0, l1_gnt1, l1_rdy0, l1_rdy1, l1_err0, l1_err1;
    logic [31:0] l1_rdata0, l1_rdata1;
    logic        l1_memWE, l1_memLB, l1_busy;
    logic [31:0] l1_memA, l1_memWD, l1_memRD;

    logic [31:0] mem [WORDS];
    logic        mem_init = 1'b0;
    logic [31:0] ref_mem [WORDS];
    logic [31:0] exp_rd [2];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.WORD_SIZE(32), .DATA_MEM_SIZE(WORDS), .MEM_LATENCY(L)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lb0(lb0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lb1(lb1),
        .gnt0(gnt0), .gnt1(gnt1), .rdy0(rdy0), .rdy1(rdy1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1),
        .memWE(memWE), .memLB(memLB), .memA(memA), .memWD(memWD), .memRD(memRD),
        .busy(busy)
    );

    data_mem_arbiter #(.WORD_SIZE(32), .DATA_MEM_SIZE(WORDS), .MEM_LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .req0(l1_req), .we0(1'b0), .addr0(l1_addr), .wdata0(32'd0), .lb0(1'b0),
        .req1(1'b0), .we1(1'b0), .addr1(32'd0), .wdata1(32'd0), .lb1(1'b0),
        .gnt0(l1_gnt0), .gnt1(l1_gnt1), .rdy0(l1_rdy0), .rdy1(l1_rdy1),
        .err0(l1_err0), .err1(l1_err1), .rdata0(l1_rdata0), .rdata1(l1_rdata1),
        .memWE(l1_memWE), .memLB(l1_memLB), .memA(l1_memA), .memWD(l1_memWD),
        .memRD(l1_memRD), .busy(l1_busy)
    );

    function automatic logic [31:0] pat(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    assign memRD    = (memA < WORDS) ? mem[memA[9:0]] : 32'hBAD0_BAD0;
    assign l1_memRD = l1_memA ^ 32'hC0FF_EE00;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= pat(i);
        end else if (memWE && memA < WORDS) begin
            mem[memA[9:0]] <= memWD;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic        lb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [8];

    // One complete transaction from an idle arbiter; returns at the next IDLE cycle.
    task automatic do_txn(input vec_t v);
        int          we_cnt = 0, we_k = 0, rdy_early = 0;
        logic [31:0] we_a = '0, we_d = '0, a_seen = '0;
        logic        lb_seen = 1'b0;
        logic        own_rdy, own_err;
        logic [31:0] own_rd, oth_rd;
        if (!v.port) begin
            req0 = 1'b1; we0 = v.we; lb0 = v.lb; addr0 = v.addr; wdata0 = v.wdata;
        end else begin
            req1 = 1'b1; we1 = v.we; lb1 = v.lb; addr1 = v.addr; wdata1 = v.wdata;
        end
        @(negedge clk);
        check("tbl_gnt", {gnt0, gnt1}, v.port ? 2'b01 : 2'b10);
        step();
        req0 = 1'b0;
        req1 = 1'b0;
        for (int k = 1; k <= L; k++) begin
            @(negedge clk);
            if (memWE) begin
                we_cnt++; we_k = k; we_a = memA; we_d = memWD;
            end
            if (k == 1) begin
                a_seen = memA; lb_seen = memLB;
            end
            if (rdy0 || rdy1) rdy_early++;
            step();
        end
        @(negedge clk);
        own_rdy = v.port ? rdy1 : rdy0;
        own_err = v.port ? err1 : err0;
        own_rd  = v.port ? rdata1 : rdata0;
        oth_rd  = v.port ? rdata0 : rdata1;
        check("tbl_rdy", {rdy0, rdy1}, v.port ? 2'b01 : 2'b10);
        check("tbl_err", {own_rdy, own_err}, {1'b1, v.exp_err});
        if (!v.we) exp_rd[v.port] = v.exp_rdata;
        check("tbl_rdata_owner", own_rd, exp_rd[v.port]);
        check("tbl_rdata_other", oth_rd, exp_rd[!v.port]);
        check("tbl_memA_lb", {a_seen, 31'd0, lb_seen}, {v.addr, 31'd0, v.lb});
        check("tbl_no_early_rdy", rdy_early, 0);
        if (v.we && !v.exp_err) begin
            check("tbl_we_count", we_cnt, 1);
            check("tbl_we_cycle", we_k, L);
            check("tbl_we_addr_data", {we_a, we_d}, {v.addr, v.wdata});
        end else begin
            check("tbl_we_count", we_cnt, 0);
        end
        step();
    endtask

    task automatic run_random(input int n);
        logic        pend [2];
        logic        seen [2];
        int          free_at = 0, g = -100;
        logic        m_last = 1'b1, m_port = 1'b0, m_we = 1'b0, m_lb = 1'b0;
        logic [31:0] m_addr = '0, m_wdata = '0;
        pend = '{1'b0, 1'b0};
        seen = '{1'b0, 1'b0};
        for (int cyc = 0; cyc < n; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (seen[p]) begin
                    pend[p] = 1'b0;
                    seen[p] = 1'b0;
                end
                if (!pend[p] && $urandom_range(3) == 0) begin
                    logic        w  = 1'(($urandom_range(1)));
                    logic        b  = 1'(($urandom_range(1)));
                    logic [31:0] a  = 32'($urandom_range(31));
                    logic [31:0] d  = $urandom;
                    if (!w && $urandom_range(7) == 0) a = 32'(WORDS + $urandom_range(7));
                    pend[p] = 1'b1;
                    if (p == 0) begin req0 = 1'b1; we0 = w; lb0 = b; addr0 = a; wdata0 = d; end
                    else        begin req1 = 1'b1; we1 = w; lb1 = b; addr1 = a; wdata1 = d; end
                end
                if (!pend[p]) begin
                    if (p == 0) req0 = 1'b0;
                    else        req1 = 1'b0;
                end
            end
            @(negedge clk);
            begin
                logic        idle = (cyc >= free_at);
                logic        e_g0 = 1'b0, e_g1 = 1'b0, e_we = 1'b0, acc, dn;
                logic        e_r0 = 1'b0, e_r1 = 1'b0, e_e0 = 1'b0, e_e1 = 1'b0;
                if (idle && (req0 || req1)) begin
                    logic win;
                    if (req0 && req1) win = !m_last;
                    else              win = req1;
                    if (win) begin e_g1 = 1'b1; m_we = we1; m_lb = lb1; m_addr = addr1; m_wdata = wdata1; end
                    else     begin e_g0 = 1'b1; m_we = we0; m_lb = lb0; m_addr = addr0; m_wdata = wdata0; end
                    m_port  = win;
                    m_last  = win;
                    g       = cyc;
                    free_at = cyc + L + 2;
                end
                acc  = (cyc > g) && (cyc <= g + L);
                dn   = (cyc == g + L + 1);
                e_we = acc && (cyc == g + L) && m_we && (m_addr < WORDS);
                if (dn) begin
                    if (m_port) begin e_r1 = 1'b1; e_e1 = (m_addr >= WORDS); end
                    else        begin e_r0 = 1'b1; e_e0 = (m_addr >= WORDS); end
                    if (!m_we) exp_rd[m_port] = (m_addr < WORDS) ? ref_mem[m_addr[9:0]] : 32'd0;
                end
                check("rnd_gnt", {gnt0, gnt1}, {e_g0, e_g1});
                check("rnd_busy_we", {busy, memWE}, {!idle, e_we});
                check("rnd_rdy_err", {rdy0, rdy1, err0, err1}, {e_r0, e_r1, e_e0, e_e1});
                check("rnd_rdata", {rdata0, rdata1}, {exp_rd[0], exp_rd[1]});
                if (acc)
                    check("rnd_bus_access", {memLB, memA, memWD}, {m_lb, m_addr, m_wdata});
                else if (idle)
                    check("rnd_bus_idle", {memLB, memA, memWD}, 65'd0);
                if (e_we) ref_mem[m_addr[9:0]] = m_wdata;
            end
            seen[0] = gnt0;
            seen[1] = gnt1;
            step();
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          gcyc [$];
        logic        gport [$];
        int          both, rdy1_cnt;
        logic [5:0]  g_mask, r_mask, b_mask;
        logic [31:0] l1_a, l1_rd;

        tbl[0] = '{1'b0, 1'b1, 1'b0, 32'd8,    32'hDEAD_BEEF, 1'b0, 32'd0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 32'd8,    32'd0,         1'b0, 32'hDEAD_BEEF};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 32'd1024, 32'd0,         1'b1, 32'd0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 32'd1023, 32'h1234_5678, 1'b0, 32'd0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 32'd1023, 32'd0,         1'b0, 32'h1234_5678};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 32'd1024, 32'hA5A5_A5A5, 1'b1, 32'd0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0,    1'b1, 32'd0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 32'd8,    32'd0,         1'b0, 32'hDEAD_BEEF};

        rst = 1'b0;
        {req0, we0, lb0, req1, we1, lb1} = '0;
        {addr0, wdata0, addr1, wdata1} = '0;
        l1_req = 1'b0; l1_addr = '0;
        exp_rd = '{32'd0, 32'd0};
        mem_init = 1'b1;
        step();
        mem_init = 1'b0;

        // Reset state, with a request present that must not be granted.
        req0 = 1'b1;
        #1;
        check("rst_gnt_rdy_err", {gnt0, gnt1, rdy0, rdy1, err0, err1}, 6'd0);
        check("rst_busy_we_lb", {busy, memWE, memLB}, 3'd0);
        check("rst_bus", {memA, memWD}, 64'd0);
        check("rst_rdata", {rdata0, rdata1}, 64'd0);
        req0 = 1'b0;
        step();
        rst = 1'b1;

        // Single-cycle latency instance with a held read request.
        l1_req = 1'b1;
        l1_addr = 32'd5;
        g_mask = '0; r_mask = '0; b_mask = '0; l1_a = '0; l1_rd = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            g_mask[c] = l1_gnt0 | l1_gnt1;
            r_mask[c] = l1_rdy0 | l1_rdy1;
            b_mask[c] = l1_busy;
            if (c == 1) l1_a = l1_memA;
            if (c == 2) l1_rd = l1_rdata0;
            step();
        end
        l1_req = 1'b0;
        check("lat1_gnt_cycles", g_mask, 6'b001001);
        check("lat1_rdy_cycles", r_mask, 6'b100100);
        check("lat1_busy_cycles", b_mask, 6'b110110);
        check("lat1_memA", l1_a, 32'd5);
        check("lat1_rdata", l1_rd, 32'd5 ^ 32'hC0FF_EE00);

        for (int i = 0; i < 8; i++) do_txn(tbl[i]);

        // Both ports requesting continuously from reset.
        rst = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd2;
        step();
        rst = 1'b1;
        both = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (gnt0 && gnt1) both++;
            if (gnt0 || gnt1) begin
                gcyc.push_back(c);
                gport.push_back(gnt1);
            end
            step();
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check("rr_both_gnt", both, 0);
        check("rr_grant_count", gcyc.size(), 4);
        for (int i = 0; i < gcyc.size() && i < 4; i++) begin
            check("rr_grant_port", gport[i], i % 2);
            check("rr_grant_cycle", gcyc[i], 5 * i);
        end
        exp_rd = '{pat(1), pat(2)};
        check("rr_rdata", {rdata0, rdata1}, {exp_rd[0], exp_rd[1]});

        // Reset during the write cycle of a port-1 access aborts it.
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'd20; wdata1 = 32'h0BAD_F00D;
        @(negedge clk);
        check("abort_gnt1", {gnt0, gnt1}, 2'b01);
        step();
        req1 = 1'b0; we1 = 1'b0;
        req0 = 1'b1; we0 = 1'b0; lb0 = 1'b0; addr0 = 32'd20;
        @(negedge clk);
        check("abort_req_ignored", {busy, gnt0, gnt1}, 3'b100);
        step();
        step();
        @(negedge clk);
        check("abort_we_before", memWE, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("abort_we_busy_drop", {memWE, busy, memA}, 34'd0);
        rdy1_cnt = 0;
        step();
        @(negedge clk);
        check("abort_held_in_reset", {gnt0, gnt1, rdy0, rdy1}, 4'd0);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("abort_regrant_p0", {gnt0, gnt1}, 2'b10);
        step();
        req0 = 1'b0;
        for (int k = 1; k <= L; k++) begin
            @(negedge clk);
            if (rdy1) rdy1_cnt++;
            step();
        end
        @(negedge clk);
        if (rdy1) rdy1_cnt++;
        check("abort_no_rdy1", rdy1_cnt, 0);
        check("abort_rdy0", rdy0, 1'b1);
        check("abort_mem_untouched", {rdata0, rdata1}, {pat(20), 32'd0});
        step();

        // Randomized traffic from a fresh reset and freshly initialized memory.
        rst = 1'b0;
        mem_init = 1'b1;
        step();
        mem_init = 1'b0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = pat(i);
        exp_rd = '{32'd0, 32'd0};
        step();
        rst = 1'b1;
        run_random(3000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 32, data and address width.
REQ-002 Parameter DATA_MEM_SIZE, default 1024, number of words in the data memory.
REQ-003 Parameter MEM_LATENCY, default 3, memory access cycles per transaction (legal range 1..15).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req0/req1  input  1  access request from port 0 (pipeline MEM stage) / port 1 (DMA/debug).
REQ-007 we0/we1  input  1  1 = write, 0 = read.
REQ-008 addr0/addr1  input  WORD_SIZE  word address.
REQ-009 wdata0/wdata1  input  WORD_SIZE  write data.
REQ-010 lb0/lb1  input  1  load-byte request, passed to the memory.
REQ-011 gnt0/gnt1  output  1  accept pulse; request fields are sampled on this cycle.
REQ-012 rdy0/rdy1  output  1  one-cycle completion pulse to the owning port.
REQ-013 err0/err1  output  1  out-of-range flag, valid only while the matching rdy is high.
REQ-014 rdata0/rdata1  output  WORD_SIZE  read data; holds its value until the next read completion on that port.
REQ-015 memWE, memLB  output  1  memory write enable and load-byte select.
REQ-016 memA, memWD  output  WORD_SIZE  memory address and write data.
REQ-017 memRD  input  WORD_SIZE  memory read data (combinational from memA/memLB).
REQ-018 busy  output  1  high when the FSM is in any state other than IDLE.

Function
REQ-019 FSM has three states: IDLE, ACCESS, DONE.
REQ-020 In IDLE with at least one req high, exactly one gnt is driven combinationally high in that cycle.
- At the following edge: the selected port's we/addr/wdata/lb and the owner ID are latched, the counter loads MEM_LATENCY-1, and the FSM moves to ACCESS.
REQ-021 Arbitration is round-robin.
- Only one req high: that port wins.
- Both high: the port not granted last wins.
- The last-grant pointer updates on entering ACCESS.
REQ-022 gnt0 and gnt1 are never both high, and are 0 outside IDLE.
REQ-023 A req in ACCESS or DONE is ignored, with no gnt, until IDLE.
- The requester holds req until it sees gnt.
REQ-024 In ACCESS, memA/memWD/memLB drive the latched values; the counter decrements each cycle.
REQ-025 memWE is high only in the ACCESS cycle where the counter is 0, only for an in-range write, and for exactly one cycle per write.
REQ-026 On the counter==0 edge:
- For an in-range read, memRD is captured into the owner's rdata register.
- The FSM moves to DONE.
REQ-027 In DONE, rdy of the owner is high for one cycle, then the FSM returns to IDLE.
- A new grant is possible in that IDLE cycle.
- Transaction spacing is therefore MEM_LATENCY+2 cycles.
REQ-028 A latched addr >= DATA_MEM_SIZE is out of range:
- memWE stays 0.
- The owner's rdata is loaded with 0.
- err is high together with rdy.
REQ-029 In IDLE: memWE=0, memLB=0, memA=0, memWD=0.
REQ-030 The rdata of the non-owning port never changes.
REQ-031 When MEM_LATENCY=1, ACCESS lasts exactly one cycle, with the counter at 0 on entry.

Reset
REQ-032 rst=0 immediately forces, without waiting for a clock edge:
- FSM to IDLE, counter to 0, last-grant pointer to port 1 (so port 0 wins the first tie).
- All gnt/rdy/err/busy/memWE/memLB to 0; memA, memWD, rdata0, rdata1 to 0.
REQ-033 Reset during ACCESS aborts the transaction:
- No memWE pulse and no rdy for it.
- Requests are re-arbitrated after rst returns to 1.

Verification
REQ-034 MEM_LATENCY=3; req0 write addr=8 wdata=0xDEADBEEF. Required response:
- gnt0 in the request cycle.
- memWE high exactly once, with memA=8, 3 cycles after gnt0.
- rdy0 one cycle later, err0=0.
REQ-035 Port 0 read addr=8 after REQ-034, memRD modelled as mem[8]. Required response:
- rdata0=0xDEADBEEF at rdy0.
- rdata1 unchanged.
REQ-036 req0 and req1 held high continuously from reset. Required response:
- Grants alternate 0,1,0,1.
- Each gnt is 5 cycles after the previous one.
- gnt0 and gnt1 are never high together.
REQ-037 req1 read addr=DATA_MEM_SIZE. Required response:
- rdy1=1 with err1=1 and rdata1=0.
- No memWE at any point.
REQ-038 Write granted to port 1, then rst pulsed low during ACCESS. Required response:
- memWE and busy drop immediately.
- No rdy1 for the aborted write.
- After release, a held req0 is granted first.
REQ-039 MEM_LATENCY=1 with a single read. Required response:
- gnt, then ACCESS for one cycle, then rdy.
- The next gnt for a held request comes 3 cycles after the first.
